// File: rtl/sigdelay_pkg.sv
// Shared types and helpers for the sample delay line.
package sigdelay_pkg;

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    // Clamp a + b into the signed range of a width-bit word.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned width);
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (width - 1));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module delay_ram #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sigdelay_stream.sv
// Streaming sample delay line with fill tracking.
// Define SIGDELAY_ECHO_EN to store signed samples with saturating echo feedback.
module sigdelay_stream #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FB_SHIFT      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    delayed_signal,
    output logic                     filled
);
    import sigdelay_pkg::*;

    state_e state;
    state_e nstate;

    logic [ADDRESS_WIDTH-1:0] eff;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [ADDRESS_WIDTH-1:0] fill_cnt;
    logic [ADDRESS_WIDTH-1:0] cnt_next;
    logic [ADDRESS_WIDTH-1:0] offset_q;
    logic                     restart;
    logic                     wen_q;
    logic                     run_q;
    logic                     fwd_q;
    logic [DATA_WIDTH-1:0]    mic_q;
    logic [DATA_WIDTH-1:0]    ram_rdata;
    logic [DATA_WIDTH-1:0]    raw;
    logic [DATA_WIDTH-1:0]    cur_out;
    logic [DATA_WIDTH-1:0]    store_data;
    logic [DATA_WIDTH-1:0]    fwd_data_q;
    logic [DATA_WIDTH-1:0]    hold_q;

    // The accepting sample counts toward the fill, so offset N leaves exactly N zero outputs.
    always_comb begin
        eff      = (offset == '0) ? ADDRESS_WIDTH'(1) : offset;
        rd_addr  = wr_addr - eff;
        restart  = (state == StIdle) || (eff != offset_q);
        cnt_next = (restart ? '0 : fill_cnt) + ADDRESS_WIDTH'(1);
        nstate   = state;
        if (in_valid && (restart || state == StFill))
            nstate = (cnt_next == eff) ? StRun : StFill;
    end

    always_comb begin
        raw     = fwd_q ? fwd_data_q : ram_rdata;
        cur_out = run_q ? raw : '0;
    end

`ifdef SIGDELAY_ECHO_EN
    logic signed [DATA_WIDTH-1:0] mic_s;
    logic signed [DATA_WIDTH-1:0] fb_s;

    always_comb begin
        mic_s      = mic_q;
        fb_s       = cur_out;
        store_data = DATA_WIDTH'(sat_add(32'(mic_s), 32'(fb_s >>> FB_SHIFT), DATA_WIDTH));
    end
`else
    always_comb begin
        store_data = mic_q;
    end
`endif

    assign delayed_signal = out_valid ? cur_out : hold_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StIdle;
            filled     <= 1'b0;
            wr_addr    <= '0;
            wr_addr_q  <= '0;
            fill_cnt   <= '0;
            offset_q   <= '0;
            out_valid  <= 1'b0;
            wen_q      <= 1'b0;
            run_q      <= 1'b0;
            fwd_q      <= 1'b0;
            mic_q      <= '0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            state      <= nstate;
            filled     <= (nstate == StRun);
            out_valid  <= in_valid;
            wen_q      <= in_valid;
            fwd_data_q <= store_data;
            if (out_valid) hold_q <= cur_out;
            if (in_valid) begin
                offset_q  <= eff;
                wr_addr   <= wr_addr + ADDRESS_WIDTH'(1);
                wr_addr_q <= wr_addr;
                mic_q     <= mic_signal;
                run_q     <= (state == StRun) && !restart;
                // Back-to-back with offset 1: the word is still in the write pipeline.
                fwd_q     <= wen_q && (rd_addr == wr_addr_q);
                if (restart || state == StFill) fill_cnt <= cnt_next;
            end
        end
    end

    delay_ram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wen_q & reset),
        .waddr(wr_addr_q),
        .wdata(store_data),
        .re   (in_valid),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

endmodule
